// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake head controller.
// The dir_t encoding equals the go[] bit index of each direction.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int GO_UP      = 0;
    localparam int GO_DOWN    = 1;
    localparam int GO_LEFT    = 2;
    localparam int GO_RIGHT   = 3;
    localparam int GO_RESTART = 4;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        r = DIR_LEFT;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_head_ctrl_tick_gen.sv
// Step pacing divider: pulses tick for one cycle every TICK_DIV enabled cycles.
// clr has priority and suppresses the pulse.
module tick_gen #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CW'(TICK_DIV - 1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: decodes change-triggered go[] commands, rejects reversals,
// moves the head one cell per tick and dies on leaving the grid.
module snake_head_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4:0]                go,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output dir_t                      dir,
    output logic                      step,
    output logic                      running,
    output logic                      game_over
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] CX = XW'(GRID_W / 2);
    localparam logic [YW-1:0] CY = YW'(GRID_H / 2);

    logic [4:0]    go_q, go_d;
    state_t        state_q, state_d;
    logic [XW-1:0] head_x_q, head_x_d, next_x;
    logic [YW-1:0] head_y_q, head_y_d, next_y;
    dir_t          dir_q, dir_d, pend_dir_q, pend_dir_d, cmd_dir;
    logic          step_q, step_d;
    logic          changed, restart_cmd, dir_cmd, next_ok, tick, tick_clr, tick_en;

    // Sticky go[]: only a change of level counts as a new press.
    assign changed     = (go != go_q);
    assign restart_cmd = changed && go[GO_RESTART] && !go_q[GO_RESTART];
    assign dir_cmd     = changed && !go[GO_RESTART] && $onehot(go[3:0]);

    always_comb begin
        cmd_dir = DIR_UP;
        if (go[GO_DOWN])  cmd_dir = DIR_DOWN;
        if (go[GO_LEFT])  cmd_dir = DIR_LEFT;
        if (go[GO_RIGHT]) cmd_dir = DIR_RIGHT;
    end

    // Edge check happens before the +/-1 so the arithmetic never wraps.
    always_comb begin
        next_x  = head_x_q;
        next_y  = head_y_q;
        next_ok = 1'b0;
        case (pend_dir_q)
            DIR_UP: begin
                next_ok = (head_y_q != '0);
                next_y  = head_y_q - YW'(1);
            end
            DIR_DOWN: begin
                next_ok = (head_y_q != YW'(GRID_H - 1));
                next_y  = head_y_q + YW'(1);
            end
            DIR_LEFT: begin
                next_ok = (head_x_q != '0);
                next_x  = head_x_q - XW'(1);
            end
            DIR_RIGHT: begin
                next_ok = (head_x_q != XW'(GRID_W - 1));
                next_x  = head_x_q + XW'(1);
            end
            default: next_ok = 1'b0;
        endcase
    end

    assign tick_clr = restart_cmd || (state_q == ST_IDLE);
    assign tick_en  = (state_q == ST_RUN);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        go_d       = go;
        state_d    = state_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        dir_d      = dir_q;
        pend_dir_d = pend_dir_q;
        step_d     = 1'b0;
        if (restart_cmd) begin
            state_d    = ST_IDLE;
            head_x_d   = CX;
            head_y_d   = CY;
            dir_d      = DIR_RIGHT;
            pend_dir_d = DIR_RIGHT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dir_cmd) begin
                        dir_d      = cmd_dir;
                        pend_dir_d = cmd_dir;
                        state_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Reversal is judged against the committed direction, not pend_dir.
                    if (dir_cmd && (cmd_dir != opposite(dir_q))) begin
                        pend_dir_d = cmd_dir;
                    end
                    if (tick) begin
                        if (next_ok) begin
                            head_x_d = next_x;
                            head_y_d = next_y;
                            dir_d    = pend_dir_q;
                            step_d   = 1'b1;
                        end else begin
                            state_d = ST_DEAD;
                        end
                    end
                end
                ST_DEAD: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            go_q       <= '0;
            state_q    <= ST_IDLE;
            head_x_q   <= CX;
            head_y_q   <= CY;
            dir_q      <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            step_q     <= 1'b0;
        end else begin
            go_q       <= go_d;
            state_q    <= state_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            dir_q      <= dir_d;
            pend_dir_q <= pend_dir_d;
            step_q     <= step_d;
        end
    end

    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign running   = (state_q == ST_RUN);
    assign game_over = (state_q == ST_DEAD);

endmodule

// File: doc/snake_head_ctrl.md
# snake_head_ctrl

Consumes the one-hot `go[4:0]` button command bus produced by the pushbutton direction selector and turns it into snake-head motion on the playfield grid. It decodes direction and restart commands, rejects 180° reversals, paces movement with an internal tick divider, and detects wall collisions. Downstream, the body/segment logic and the VGA renderer read its head position, its `step` pulse and its game state.

## Interface
**Parameters**
- `GRID_W`, default 32: playfield columns.
- `GRID_H`, default 24: playfield rows.
- `TICK_DIV`, default 5_000_000: `clk` cycles per step (20 steps/s at 100 MHz). Must be ≥ 2.

**Ports**
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `go` in 5: one-hot command. Bit 0 up, bit 1 down, bit 2 left, bit 3 right, bit 4 restart. The level is sticky: it holds the last press.
- `head_x` out `$clog2(GRID_W)`: head column, 0 = left edge.
- `head_y` out `$clog2(GRID_H)`: head row, 0 = top edge.
- `dir` out 2: committed direction, `dir_t`.
- `step` out 1: one-cycle pulse when the head moves.
- `running` out 1: high in RUN.
- `game_over` out 1: high in DEAD.

## Operation
- **Command sampling**
  - `go` is registered into `go_q`.
  - A command is acted on only in a cycle where `go != go_q` (change-triggered), because `go` is sticky.
- **Decode**
  - Restart: rising edge of `go[4]`.
  - Direction: `go[3:0]` exactly one-hot with `go[4]=0`.
  - Any other pattern (zero or multi-hot) is ignored.
- **FSM states**
  - IDLE (reset state): head parked at centre (`GRID_W/2`, `GRID_H/2`), tick counter held at 0.
    - A direction command sets `pend_dir` and `dir`, clears the counter and moves to RUN.
    - No reversal check in IDLE.
  - RUN: the tick counter runs from 0 to `TICK_DIV-1` and wraps.
    - Direction command: accepted into `pend_dir` unless it is the opposite of the committed `dir`. The check is against committed `dir`, not `pend_dir`, so two quick turns cannot reverse within one step.
    - On wrap, compute next = head moved one cell in `pend_dir`. Up is y−1, down y+1, left x−1, right x+1.
    - If next is in range: update head, set `dir <= pend_dir`, pulse `step`.
    - If next is out of range: go to DEAD, head unchanged, no `step`.
  - DEAD: head, `dir` and counter frozen. Direction commands are ignored.
  - Restart from any state: go to IDLE, head re-centred, `dir <= DIR_RIGHT`, counter cleared, `pend_dir <= DIR_RIGHT`.
- **No wrap-around.** Edges are fatal; all bounds are checked before any arithmetic, so there is no underflow.

## Timing
- **Reset values**
  - `head_x = GRID_W/2`, `head_y = GRID_H/2`
  - `dir = DIR_RIGHT`
  - `step = 0`, `running = 0`, `game_over = 0`
  - `go_q = 0`, state IDLE
- **Command latency:** `go` change before edge k takes effect at edge k (state, `pend_dir` and `dir` visible after k).
- **First step:** occurs `TICK_DIV` cycles after the IDLE→RUN edge. Thereafter one step every `TICK_DIV` cycles.
- **Step output:** `step` is registered and coincides with the new `head_x`/`head_y` values.
- **Simultaneous events**
  - Restart and step in the same cycle: restart wins, no `step`.
  - Direction command and step in the same cycle: the step uses the old `pend_dir`; the new direction applies to the next step, with its reversal check made against the pre-step `dir`.
- **Held restart:** holding `go = 5'b10000` restarts exactly once.
- **Mid-operation reset:** `rst_n` low during RUN or DEAD forces the reset values on the next edge.

## Structure
- **Package `snake_pkg`**
  - `typedef enum logic [1:0] dir_t` = {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - `typedef enum logic [1:0] state_t` = {ST_IDLE, ST_RUN, ST_DEAD}
  - `go` bit-index constants GO_UP=0 … GO_RESTART=4
  - function `opposite(dir_t)`
- **Sub-module `tick_gen`** (parameter `TICK_DIV`; inputs `clk`, `rst_n`, `clr`, `en`; output `tick`), instantiated once. Everything else is in `snake_head_ctrl`.

## Test plan
All scenarios use `GRID_W=8`, `GRID_H=6`, `TICK_DIV=4`, so centre = (4,3).
1. **Reset:** hold `rst_n=0` for 3 cycles → head (4,3), `dir=RIGHT`, `step/running/game_over = 0`. With `go=0`, the block stays IDLE for 20 cycles with no `step`.
2. **Start:** `go=5'b01000` → `running=1` next edge. `step` fires 4 cycles later with head (5,3), then (6,3) after 4 more cycles.
3. **Reversal rejection:** while moving right, `go=5'b00100` → head continues to x+1. Then `go=5'b00001` followed by `go=5'b00100` within one step period → the up turn is taken, the left is rejected, head (x,2).
4. **Wall:** moving right at x=7 → at the next tick `game_over=1`, `running=0`, head stays (7,3), no `step`. A following `go=5'b00010` is ignored.
5. **Restart:** from DEAD, `go=5'b10000` held 50 cycles → IDLE once, head (4,3), `game_over=0`. A later `go=5'b00001` restarts motion upward to (4,2).
6. **Collisions of events:** restart edge in the exact wrap cycle → no `step`, head (4,3). Invalid `go=5'b00101` in RUN → `pend_dir` unchanged.
